// File: rtl/sqemac_pkg.sv
// Shared constants, complex payload type and arithmetic helpers for the 8-point FFT core.
package sqemac_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = 12;
    localparam int unsigned TW_C = 181;
    localparam int unsigned NPT  = 8;
    localparam int unsigned PW   = IW + 9;

    localparam logic signed [IW-1:0] SAT_HI = IW'(127);
    localparam logic signed [IW-1:0] SAT_LO = IW'(-128);
    localparam logic signed [PW-1:0] TW_S   = PW'(TW_C);

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cplx_t;

    function automatic logic [DW-1:0] sat8(input logic signed [IW-1:0] v);
        logic [DW-1:0] r;
        if (v > SAT_HI) begin
            r = DW'(SAT_HI);
        end else if (v < SAT_LO) begin
            r = DW'(SAT_LO);
        end else begin
            r = DW'(v);
        end
        return r;
    endfunction

    // Q8 multiply by cos(pi/4), floored by the arithmetic shift
    function automatic logic signed [IW-1:0] cmul_c(input logic signed [IW-1:0] s);
        logic signed [PW-1:0] p;
        p = PW'(s) * TW_S;
        return IW'(p >>> 8);
    endfunction

    function automatic cplx_t mk_real(input logic signed [IW-1:0] r);
        cplx_t z;
        z.re = r;
        z.im = '0;
        return z;
    endfunction

    // Multiply by -j: (re, im) -> (im, -re)
    function automatic cplx_t mul_nj(input cplx_t z);
        cplx_t y;
        y.re = z.im;
        y.im = -z.re;
        return y;
    endfunction

endpackage

// File: rtl/sqemac_bfly.sv
// Combinational complex butterfly: sum = a + b, dif = a - b.
module sqemac_bfly
    import sqemac_pkg::*;
(
    input  cplx_t a_i,
    input  cplx_t b_i,
    output cplx_t sum_c_o,
    output cplx_t dif_c_o
);

    always_comb begin
        sum_c_o.re = a_i.re + b_i.re;
        sum_c_o.im = a_i.im + b_i.im;
        dif_c_o.re = a_i.re - b_i.re;
        dif_c_o.im = a_i.im - b_i.im;
    end

endmodule

// File: rtl/sqemac_fft8.sv
// 8-point radix-2 DIT FFT of real signed samples; input register plus three
// registered butterfly stages, one vector per clock, saturated 8-bit bins.
module sqemac_fft8
    import sqemac_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] VAR0,
    input  logic [DW-1:0] VAR1,
    input  logic [DW-1:0] VAR2,
    input  logic [DW-1:0] VAR3,
    input  logic [DW-1:0] VAR4,
    input  logic [DW-1:0] VAR5,
    input  logic [DW-1:0] VAR6,
    input  logic [DW-1:0] VAR7,
    output logic          out_valid,
    output logic [DW-1:0] M1R,
    output logic [DW-1:0] M2R,
    output logic [DW-1:0] M3R,
    output logic [DW-1:0] M4R,
    output logic [DW-1:0] M5R,
    output logic [DW-1:0] M6R,
    output logic [DW-1:0] M7R,
    output logic [DW-1:0] M8R,
    output logic [DW-1:0] M1Im,
    output logic [DW-1:0] M2Im,
    output logic [DW-1:0] M3Im,
    output logic [DW-1:0] M4Im,
    output logic [DW-1:0] M5Im,
    output logic [DW-1:0] M6Im,
    output logic [DW-1:0] M7Im,
    output logic [DW-1:0] M8Im
);

    logic                 v0_q, v1_q, v2_q, out_valid_q;
    logic signed [DW-1:0] x_q  [NPT];
    logic signed [IW-1:0] a_d  [NPT];
    logic signed [IW-1:0] a_q  [NPT];
    cplx_t                s2_a [4];
    cplx_t                s2_b [4];
    cplx_t                s2_sum [4];
    cplx_t                s2_dif [4];
    cplx_t                e_d  [4];
    cplx_t                e_q  [4];
    cplx_t                o_d  [4];
    cplx_t                o_q  [4];
    cplx_t                s3_b [4];
    cplx_t                s3_sum [4];
    cplx_t                s3_dif [4];
    logic [DW-1:0]        mr_d [NPT];
    logic [DW-1:0]        mi_d [NPT];
    logic [DW-1:0]        mr_q [NPT];
    logic [DW-1:0]        mi_q [NPT];

    // Stage 1: real pair sums/differences (x_k with x_k+4)
    always_comb begin
        a_d[0] = IW'(x_q[0]) + IW'(x_q[4]);
        a_d[1] = IW'(x_q[0]) - IW'(x_q[4]);
        a_d[2] = IW'(x_q[2]) + IW'(x_q[6]);
        a_d[3] = IW'(x_q[2]) - IW'(x_q[6]);
        a_d[4] = IW'(x_q[1]) + IW'(x_q[5]);
        a_d[5] = IW'(x_q[1]) - IW'(x_q[5]);
        a_d[6] = IW'(x_q[3]) + IW'(x_q[7]);
        a_d[7] = IW'(x_q[3]) - IW'(x_q[7]);
    end

    // Stage 2 operands: the -j factor on the odd pairs folds into the b input
    always_comb begin
        s2_a[0] = mk_real(a_q[0]);
        s2_b[0] = mk_real(a_q[2]);
        s2_a[1] = mk_real(a_q[1]);
        s2_b[1] = mul_nj(mk_real(a_q[3]));
        s2_a[2] = mk_real(a_q[4]);
        s2_b[2] = mk_real(a_q[6]);
        s2_a[3] = mk_real(a_q[5]);
        s2_b[3] = mul_nj(mk_real(a_q[7]));
    end

    for (genvar g = 0; g < 4; g++) begin : g_s2
        sqemac_bfly u_bfly (
            .a_i     (s2_a[g]),
            .b_i     (s2_b[g]),
            .sum_c_o (s2_sum[g]),
            .dif_c_o (s2_dif[g])
        );
    end

    always_comb begin
        e_d[0] = s2_sum[0];
        e_d[2] = s2_dif[0];
        e_d[1] = s2_sum[1];
        e_d[3] = s2_dif[1];
        o_d[0] = s2_sum[2];
        o_d[2] = s2_dif[2];
        o_d[1] = s2_sum[3];
        o_d[3] = s2_dif[3];
    end

    // Stage 3 twiddles: W^0, W^1, W^2 = -j, W^3
    always_comb begin
        s3_b[0]    = o_q[0];
        s3_b[1].re = cmul_c(o_q[1].re + o_q[1].im);
        s3_b[1].im = cmul_c(o_q[1].im - o_q[1].re);
        s3_b[2]    = mul_nj(o_q[2]);
        s3_b[3].re = cmul_c(o_q[3].im - o_q[3].re);
        s3_b[3].im = cmul_c(-(o_q[3].re + o_q[3].im));
    end

    for (genvar g = 0; g < 4; g++) begin : g_s3
        sqemac_bfly u_bfly (
            .a_i     (e_q[g]),
            .b_i     (s3_b[g]),
            .sum_c_o (s3_sum[g]),
            .dif_c_o (s3_dif[g])
        );
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mr_d[k]   = sat8(s3_sum[k].re);
            mi_d[k]   = sat8(s3_sum[k].im);
            mr_d[k+4] = sat8(s3_dif[k].re);
            mi_d[k+4] = sat8(s3_dif[k].im);
        end
    end

    // Valid chain and result registers; reset kills every in-flight vector
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NPT; k++) begin
                mr_q[k] <= '0;
                mi_q[k] <= '0;
            end
        end else begin
            v0_q        <= in_valid;
            v1_q        <= v0_q;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                for (int k = 0; k < NPT; k++) begin
                    mr_q[k] <= mr_d[k];
                    mi_q[k] <= mi_d[k];
                end
            end
        end
    end

    // Datapath registers load only when their stage carries a vector
    always_ff @(posedge clk) begin
        if (in_valid) begin
            x_q[0] <= VAR0;
            x_q[1] <= VAR1;
            x_q[2] <= VAR2;
            x_q[3] <= VAR3;
            x_q[4] <= VAR4;
            x_q[5] <= VAR5;
            x_q[6] <= VAR6;
            x_q[7] <= VAR7;
        end
        if (v0_q) begin
            for (int k = 0; k < NPT; k++) begin
                a_q[k] <= a_d[k];
            end
        end
        if (v1_q) begin
            for (int k = 0; k < 4; k++) begin
                e_q[k] <= e_d[k];
                o_q[k] <= o_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign M1R  = mr_q[0];
    assign M2R  = mr_q[1];
    assign M3R  = mr_q[2];
    assign M4R  = mr_q[3];
    assign M5R  = mr_q[4];
    assign M6R  = mr_q[5];
    assign M7R  = mr_q[6];
    assign M8R  = mr_q[7];
    assign M1Im = mi_q[0];
    assign M2Im = mi_q[1];
    assign M3Im = mi_q[2];
    assign M4Im = mi_q[3];
    assign M5Im = mi_q[4];
    assign M6Im = mi_q[5];
    assign M7Im = mi_q[6];
    assign M8Im = mi_q[7];

endmodule

// File: tb/tb_sqemac_fft8.sv
// Self-checking bench for sqemac_fft8: integer FFT reference model with a
// due-cycle scoreboard, directed literal vectors and randomized streaming.
module tb_sqemac_fft8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] vin;
    logic        out_valid;
    logic [7:0]  m_re [8];
    logic [7:0]  m_im [8];
    logic [63:0] dut_re;
    logic [63:0] dut_im;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    sqemac_fft8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .VAR0      (vin[7:0]),
        .VAR1      (vin[15:8]),
        .VAR2      (vin[23:16]),
        .VAR3      (vin[31:24]),
        .VAR4      (vin[39:32]),
        .VAR5      (vin[47:40]),
        .VAR6      (vin[55:48]),
        .VAR7      (vin[63:56]),
        .out_valid (out_valid),
        .M1R       (m_re[0]),
        .M2R       (m_re[1]),
        .M3R       (m_re[2]),
        .M4R       (m_re[3]),
        .M5R       (m_re[4]),
        .M6R       (m_re[5]),
        .M7R       (m_re[6]),
        .M8R       (m_re[7]),
        .M1Im      (m_im[0]),
        .M2Im      (m_im[1]),
        .M3Im      (m_im[2]),
        .M4Im      (m_im[3]),
        .M5Im      (m_im[4]),
        .M6Im      (m_im[5]),
        .M7Im      (m_im[6]),
        .M8Im      (m_im[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            dut_re[8*k +: 8] = m_re[k];
            dut_im[8*k +: 8] = m_im[k];
        end
    end

    // ---------------- reference model ----------------
    function automatic int cm(input int s);
        int p;
        int q;
        p = s * 181;
        q = p / 256;
        if ((p % 256) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void fft_ref(input logic [63:0] v, output logic [63:0] re, output logic [63:0] im);
        int x[8];
        int a[8];
        int er[4], ei[4], or_[4], oi[4];
        int xr[8], xi[8];
        int t1r, t1i, t3r, t3i;
        for (int k = 0; k < 8; k++) x[k] = int'($signed(v[8*k +: 8]));
        a[0] = x[0] + x[4]; a[1] = x[0] - x[4];
        a[2] = x[2] + x[6]; a[3] = x[2] - x[6];
        a[4] = x[1] + x[5]; a[5] = x[1] - x[5];
        a[6] = x[3] + x[7]; a[7] = x[3] - x[7];
        er[0] = a[0] + a[2]; ei[0] = 0;
        er[2] = a[0] - a[2]; ei[2] = 0;
        er[1] = a[1];        ei[1] = -a[3];
        er[3] = a[1];        ei[3] = a[3];
        or_[0] = a[4] + a[6]; oi[0] = 0;
        or_[2] = a[4] - a[6]; oi[2] = 0;
        or_[1] = a[5];        oi[1] = -a[7];
        or_[3] = a[5];        oi[3] = a[7];
        t1r = cm(or_[1] + oi[1]);    t1i = cm(oi[1] - or_[1]);
        t3r = cm(oi[3] - or_[3]);    t3i = cm(-(or_[3] + oi[3]));
        xr[0] = er[0] + or_[0];  xi[0] = ei[0] + oi[0];
        xr[4] = er[0] - or_[0];  xi[4] = ei[0] - oi[0];
        xr[2] = er[2] + oi[2];   xi[2] = ei[2] - or_[2];
        xr[6] = er[2] - oi[2];   xi[6] = ei[2] + or_[2];
        xr[1] = er[1] + t1r;     xi[1] = ei[1] + t1i;
        xr[5] = er[1] - t1r;     xi[5] = ei[1] - t1i;
        xr[3] = er[3] + t3r;     xi[3] = ei[3] + t3i;
        xr[7] = er[3] - t3r;     xi[7] = ei[3] - t3i;
        for (int k = 0; k < 8; k++) begin
            re[8*k +: 8] = 8'(sat(xr[k]));
            im[8*k +: 8] = 8'(sat(xi[k]));
        end
    endfunction

    typedef struct packed {
        int          due;
        logic [63:0] re;
        logic [63:0] im;
    } ent_t;

    ent_t        sb_q[$];
    int          cyc = 0;
    logic        exp_ov = 1'b0;
    logic [63:0] exp_re = '0;
    logic [63:0] exp_im = '0;
    logic [63:0] mdl_re, mdl_im;
    ent_t        ent;

    // Each accepted vector is due 3 edges later; reset drops everything pending
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            sb_q.delete();
            exp_ov = 1'b0;
            exp_re = '0;
            exp_im = '0;
        end else begin
            exp_ov = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_ov = 1'b1;
                exp_re = sb_q[0].re;
                exp_im = sb_q[0].im;
                void'(sb_q.pop_front());
            end
            if (in_valid) begin
                fft_ref(vin, mdl_re, mdl_im);
                ent.due = cyc + 3;
                ent.re  = mdl_re;
                ent.im  = mdl_im;
                sb_q.push_back(ent);
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (out_valid !== exp_ov || dut_re !== exp_re || dut_im !== exp_im) begin
                n_err++;
                $display("FAIL cycle %0d: out_valid=%b re=%h im=%h, expected out_valid=%b re=%h im=%h",
                         cyc, out_valid, dut_re, dut_im, exp_ov, exp_re, exp_im);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic iv, input logic [63:0] v);
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        vin      = v;
    endtask

    task automatic check_lit(input string nm, input logic ov, input logic [63:0] er, input logic [63:0] ei);
        n_vec++;
        if (out_valid !== ov || dut_re !== er || dut_im !== ei) begin
            n_err++;
            $display("FAIL %s: out_valid=%b re=%h im=%h, expected out_valid=%b re=%h im=%h",
                     nm, out_valid, dut_re, dut_im, ov, er, ei);
        end
    endtask

    task automatic check_model(input string nm, input logic [63:0] v, input logic [63:0] er, input logic [63:0] ei);
        logic [63:0] r, i;
        fft_ref(v, r, i);
        n_vec++;
        if (r !== er || i !== ei) begin
            n_err++;
            $display("FAIL model %s: re=%h im=%h, expected re=%h im=%h", nm, r, i, er, ei);
        end
    endtask

    task automatic pin(input string nm, input logic [63:0] v, input logic [63:0] er, input logic [63:0] ei);
        check_model(nm, v, er, ei);
        drive(1'b0, 1'b1, v);
        repeat (4) drive(1'b0, 1'b0, '0);
        check_lit(nm, 1'b1, er, ei);
    endtask

    localparam logic [63:0] V_IMP   = 64'h0000_0000_0000_0001;
    localparam logic [63:0] V_MIX   = 64'h02_00_FC_05_03_FE_01_02;
    localparam logic [63:0] V_SHIFT = 64'h0000_0000_0000_6400;
    localparam logic [63:0] R_MIX   = 64'h00_09_FB_03_FA_09_FF_07;
    localparam logic [63:0] I_MIX   = 64'h03_F8_07_00_F9_08_FD_00;
    localparam logic [63:0] R_SHIFT = 64'h47_00_BA_9C_B9_00_46_64;
    localparam logic [63:0] I_SHIFT = 64'h47_64_47_00_B9_9C_B9_00;

    initial begin
        logic [63:0] rv;
        logic        iv;
        logic        rr;
        int          sel;
        rst      = 1'b1;
        in_valid = 1'b1;
        vin      = V_MIX;
        repeat (2) @(negedge clk);
        check_lit("reset_state", 1'b0, '0, '0);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, '0);

        pin("impulse",   V_IMP,   64'h0101_0101_0101_0101, '0);
        pin("mixed",     V_MIX,   R_MIX, I_MIX);
        pin("shifted",   V_SHIFT, R_SHIFT, I_SHIFT);
        pin("sat_7f",    64'h7F7F_7F7F_7F7F_7F7F, 64'h7F, '0);
        pin("sat_80",    64'h8080_8080_8080_8080, 64'h80, '0);

        // Back-to-back vectors with in_valid held high
        drive(1'b0, 1'b1, V_MIX);
        drive(1'b0, 1'b1, V_SHIFT);
        repeat (3) drive(1'b0, 1'b0, '0);
        check_lit("stream_first", 1'b1, R_MIX, I_MIX);
        drive(1'b0, 1'b0, '0);
        check_lit("stream_second", 1'b1, R_SHIFT, I_SHIFT);
        drive(1'b0, 1'b0, '0);
        check_lit("stream_gap", 1'b0, R_SHIFT, I_SHIFT);

        // Reset mid-stream with in_valid high
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, {$urandom, $urandom});
        drive(1'b1, 1'b1, {$urandom, $urandom});
        drive(1'b0, 1'b1, {$urandom, $urandom});
        check_lit("reset_midstream", 1'b0, '0, '0);
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, {$urandom, $urandom});

        // Randomized streaming with occasional extremes and resets
        for (int k = 0; k < 400; k++) begin
            rv  = {$urandom, $urandom};
            iv  = ($urandom_range(0, 9) < 7);
            rr  = 1'b0;
            sel = int'($urandom_range(0, 31));
            if (sel == 0) rv = 64'h7F7F_7F7F_7F7F_7F7F;
            if (sel == 1) rv = 64'h8080_8080_8080_8080;
            if (sel == 2) rv = 64'h807F_807F_807F_807F;
            if (sel == 3) rv = 64'h7F80_7F80_8080_7F7F;
            if (sel == 4) rr = 1'b1;
            drive(rr, iv, rv);
        end
        repeat (6) drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
